// File: rtl/image_rom_pkg.sv
// image_rom_pkg: shared constants for the sprite image ROM and its requester-index width helper.
package image_rom_pkg;
  localparam int ROM_DEPTH = 80896;
  localparam int ADDR_W = 19;
  localparam int RGB_W = 12;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first asserted req at or after start (with wrap).
// Ports: req (request vector), start (search origin), onehot (winner one-hot), idx (winner index).
module rr_pick import image_rom_pkg::*; #(
  parameter int N = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  // Scan offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    onehot = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(start) + i) % N]) begin
        onehot = '0;
        onehot[(int'(start) + i) % N] = 1'b1;
        idx = IW'((int'(start) + i) % N);
      end
    end
  end
endmodule

// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter: round-robin, burst-bounded sharing of the 1-cycle-latency sprite ROM.
// Ports: clk, rst (sync active-high); req/addr per requester; gnt one-hot grant (combinational);
// rom_address/rom_rgb to/from the ROM; rgb_out/rgb_valid per-requester returned pixel and strobe;
// oor_err sticky out-of-range flag.
module image_rom_arbiter import image_rom_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = image_rom_pkg::ADDR_W,
  parameter int RGB_W = image_rom_pkg::RGB_W,
  parameter int ROM_DEPTH = image_rom_pkg::ROM_DEPTH,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [ADDR_W-1:0]          rom_address,
  input  logic [RGB_W-1:0]           rom_rgb,
  output logic [NUM_REQ*RGB_W-1:0]   rgb_out,
  output logic [NUM_REQ-1:0]         rgb_valid,
  output logic                       oor_err
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(ROM_DEPTH);
  logic [IW-1:0] last_owner, start, pick_idx, gidx, p1_owner;
  logic [NUM_REQ-1:0] pick_oh;
  logic [BW-1:0] burst_cnt;
  logic active, sticky, any, oor, p1_valid, p1_oor;
  // Searching from last_owner+1 puts last_owner at the end, so a lone requester keeps the ROM.
  assign start = (last_owner == LAST) ? '0 : last_owner + 1'b1;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req),
    .start(start),
    .onehot(pick_oh),
    .idx(pick_idx)
  );
  assign any = |req;
  assign sticky = active && req[last_owner] && (burst_cnt < MAX_B);
  assign gidx = sticky ? last_owner : pick_idx;
  assign gnt = sticky ? (NUM_REQ'(1) << last_owner) : pick_oh;
  assign rom_address = any ? addr[gidx*ADDR_W +: ADDR_W] : '0;
  assign oor = rom_address >= DEPTH;
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= LAST;
      burst_cnt <= '0;
      active <= 1'b0;
      p1_valid <= 1'b0;
      p1_owner <= '0;
      p1_oor <= 1'b0;
      rgb_out <= '0;
      rgb_valid <= '0;
      oor_err <= 1'b0;
    end else begin
      active <= any;
      p1_valid <= any;
      p1_owner <= gidx;
      p1_oor <= oor;
      oor_err <= oor_err | (any & oor);
      if (any) begin
        last_owner <= gidx;
        burst_cnt <= (gidx == last_owner && active) ? ((burst_cnt == MAX_B) ? burst_cnt : burst_cnt + 1'b1) : BW'(1);
      end
      rgb_valid <= p1_valid ? (NUM_REQ'(1) << p1_owner) : '0;
      if (p1_valid) rgb_out[p1_owner*RGB_W +: RGB_W] <= p1_oor ? '0 : rom_rgb;
    end
  end
endmodule

// File: tb/tb_image_rom_arbiter.sv
// tb_image_rom_arbiter: directed and randomized checks of image_rom_arbiter against a behavioural model.
module tb_image_rom_arbiter;
  localparam int MB = 4;
  localparam int DEPTH = 80896;
  typedef struct {int due; int owner; logic [11:0] d;} ret_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = '0;
  logic [37:0] addr = '0;
  logic [1:0] gnt, rgb_valid;
  logic [18:0] rom_address;
  logic [11:0] rom_rgb = '0;
  logic [23:0] rgb_out;
  logic oor_err;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int m_last = 1;
  int m_streak = 0;
  bit m_active = 1'b0;
  bit m_oor = 1'b0;
  logic [11:0] m_rgb [2];
  ret_t q[$];
  image_rom_arbiter #(.NUM_REQ(2), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .addr(addr),
    .gnt(gnt),
    .rom_address(rom_address),
    .rom_rgb(rom_rgb),
    .rgb_out(rgb_out),
    .rgb_valid(rgb_valid),
    .oor_err(oor_err)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] rom_fn(input logic [18:0] a);
    return (a == 19'd5) ? 12'hABC : (a[11:0] ^ {a[18:12], 5'b10101});
  endfunction
  always @(posedge clk) rom_rgb <= rom_fn(rom_address);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    m_last = 1;
    m_streak = 0;
    m_active = 1'b0;
    m_oor = 1'b0;
    m_rgb[0] = '0;
    m_rgb[1] = '0;
    q.delete();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    addr = '0;
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    model_reset();
  endtask
  task automatic step(input logic [1:0] r, input logic [18:0] a0, input logic [18:0] a1, output int g);
    logic [18:0] ga;
    logic [1:0] ev;
    int eg;
    req = r;
    addr = {a1, a0};
    #1;
    eg = -1;
    if (m_active && r[m_last] && m_streak < MB) eg = m_last;
    else for (int i = 1; i <= 2; i++) if (eg < 0 && r[(m_last + i) % 2]) eg = (m_last + i) % 2;
    ga = (eg == 1) ? a1 : (eg == 0) ? a0 : 19'd0;
    chk("gnt", 64'(gnt), (eg < 0) ? 64'd0 : (64'd1 << eg));
    chk("rom_address", 64'(rom_address), 64'(ga));
    ev = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev[q[0].owner] = 1'b1;
      m_rgb[q[0].owner] = q[0].d;
      void'(q.pop_front());
    end
    chk("rgb_valid", 64'(rgb_valid), 64'(ev));
    chk("rgb_out", 64'(rgb_out), 64'({m_rgb[1], m_rgb[0]}));
    chk("oor_err", 64'(oor_err), 64'(m_oor));
    if (eg >= 0) begin
      m_streak = (eg == m_last && m_active) ? ((m_streak < MB) ? m_streak + 1 : MB) : 1;
      m_last = eg;
      m_active = 1'b1;
      q.push_back('{cyc + 2, eg, (int'(ga) >= DEPTH) ? 12'h000 : rom_fn(ga)});
      if (int'(ga) >= DEPTH) m_oor = 1'b1;
    end else m_active = 1'b0;
    g = eg;
    @(negedge clk);
    cyc++;
  endtask
  function automatic logic [18:0] rnd_addr();
    return ($urandom_range(0, 15) == 0) ? 19'(DEPTH + $urandom_range(0, 1000)) : 19'($urandom_range(0, DEPTH - 1));
  endfunction
  initial begin
    int g;
    logic [1:0] rc;
    logic [18:0] ac [2];
    model_reset();
    @(negedge clk);
    do_reset();
    step(2'b01, 19'd5, 19'd0, g);
    chk("first_grant_owner", 64'(g), 64'd0);
    step(2'b00, 19'd0, 19'd0, g);
    step(2'b00, 19'd0, 19'd0, g);
    chk("word5_pixel", 64'(rgb_out[11:0]), 64'h0ABC);
    do_reset();
    for (int n = 0; n < 20; n++) step(2'b11, rnd_addr() % 19'd80000, rnd_addr() % 19'd80000, g);
    for (int n = 0; n < 3; n++) step(2'b00, 19'd0, 19'd0, g);
    do_reset();
    for (int n = 0; n < 40; n++) step(2'b01, 19'(n * 7), 19'd0, g);
    step(2'b00, 19'd0, 19'd0, g);
    do_reset();
    step(2'b11, 19'd10, 19'd20, g);
    step(2'b11, 19'd11, 19'd20, g);
    step(2'b10, 19'd0, 19'd20, g);
    chk("handover_owner", 64'(g), 64'd1);
    step(2'b00, 19'd0, 19'd0, g);
    step(2'b00, 19'd0, 19'd0, g);
    do_reset();
    step(2'b10, 19'd0, 19'd80896, g);
    for (int n = 0; n < 4; n++) step(2'b00, 19'd0, 19'd0, g);
    chk("oor_sticky", 64'(oor_err), 64'd1);
    step(2'b01, 19'd3, 19'd0, g);
    step(2'b00, 19'd0, 19'd0, g);
    step(2'b00, 19'd0, 19'd0, g);
    do_reset();
    chk("oor_cleared", 64'(oor_err), 64'd0);
    step(2'b01, 19'd5, 19'd0, g);
    do_reset();
    for (int n = 0; n < 3; n++) step(2'b00, 19'd0, 19'd0, g);
    step(2'b11, 19'd100, 19'd200, g);
    chk("post_reset_winner", 64'(g), 64'd0);
    rc = '0;
    g = -1;
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) begin
        do_reset();
        rc = '0;
        g = -1;
      end
      for (int k = 0; k < 2; k++) begin
        if (!rc[k] || g == k) begin
          rc[k] = ($urandom_range(0, 3) != 0);
          ac[k] = rnd_addr();
        end
      end
      step(rc, ac[0], ac[1], g);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
